// File: rtl/ram_copy_dma.sv
// rtl/ram_copy_dma.sv - word-granular copy/fill DMA engine driving a dual-port RAM
// Port 1 is the read master (source), port 2 the write master (destination).
module ram_copy_dma #(
  parameter int RAM_SIZE = 8192,
  parameter int LEN_W    = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      pattern_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_o,
  output logic [LEN_W-1:0] words_o,
  output logic             req1_o,
  output logic             we1_o,
  output logic [3:0]       be1_o,
  output logic [31:0]      addr1_o,
  output logic [31:0]      wdata1_o,
  input  logic             rvalid1_i,
  input  logic [31:0]      rdata1_i,
  output logic             req2_o,
  output logic             we2_o,
  output logic [3:0]       be2_o,
  output logic [31:0]      addr2_o,
  output logic [31:0]      wdata2_o,
  input  logic             rvalid2_i,
  input  logic [31:0]      rdata2_i
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RD, S_WT, S_WR, S_DONE
  } state_t;

  state_t           r_state;
  logic             r_mode;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_rem;
  logic [31:0]      r_pattern;
  logic             r_abort;
  logic [TMO_W-1:0] r_tmo;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_err;
  logic [LEN_W-1:0] r_words;
  logic             r_req1;
  logic [31:0]      r_addr1;
  logic             r_req2;
  logic [31:0]      r_addr2;
  logic [31:0]      r_wdata2;

  // Range ends computed at 34 bits so a huge length or high base cannot wrap.
  logic [33:0] w_bytes;
  logic [33:0] w_src_end;
  logic [33:0] w_dst_end;
  logic        w_bad;
  logic        w_abort;
  logic        w_unused_port2;

  assign w_bytes   = 34'(r_rem) << 2;
  assign w_src_end = {2'b00, r_src} + w_bytes;
  assign w_dst_end = {2'b00, r_dst} + w_bytes;
  assign w_bad     = (r_rem == '0) || (r_src[1:0] != 2'b00) || (r_dst[1:0] != 2'b00) ||
                     (w_dst_end > 34'(RAM_SIZE)) || (!r_mode && (w_src_end > 34'(RAM_SIZE)));
  assign w_abort   = r_abort | abort_i;
  assign w_unused_port2 = ^{rvalid2_i, rdata2_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_pattern <= '0;
      r_abort   <= 1'b0;
      r_tmo     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 2'd0;
      r_words   <= '0;
      r_req1    <= 1'b0;
      r_addr1   <= '0;
      r_req2    <= 1'b0;
      r_addr2   <= '0;
      r_wdata2  <= '0;
    end else begin
      r_done <= 1'b0;
      r_req1 <= 1'b0;
      r_req2 <= 1'b0;
      if (abort_i && r_state != S_IDLE) r_abort <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mode    <= mode_i;
            r_src     <= src_addr_i;
            r_dst     <= dst_addr_i;
            r_rem     <= len_i;
            r_pattern <= pattern_i;
            r_abort   <= 1'b0;
            r_words   <= '0;
            r_err     <= 2'd0;
            r_busy    <= 1'b1;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_bad) begin
            r_err   <= 2'd1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_mode) begin
            r_req2   <= 1'b1;
            r_addr2  <= r_dst;
            r_wdata2 <= r_pattern;
            r_state  <= S_WR;
          end else begin
            r_req1  <= 1'b1;
            r_addr1 <= r_src;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_tmo   <= '0;
          r_state <= S_WT;
        end
        S_WT: begin
          // The write-data register doubles as the read buffer.
          if (rvalid1_i) begin
            r_req2   <= 1'b1;
            r_addr2  <= r_dst;
            r_wdata2 <= rdata1_i;
            r_state  <= S_WR;
          end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            r_err   <= 2'd2;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_WR: begin
          r_words <= r_words + LEN_W'(1);
          r_src   <= r_src + 32'd4;
          r_dst   <= r_dst + 32'd4;
          r_rem   <= r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1) || w_abort) begin
            r_err   <= (r_rem == LEN_W'(1)) ? 2'd0 : 2'd3;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_mode) begin
            r_req2   <= 1'b1;
            r_addr2  <= r_dst + 32'd4;
            r_wdata2 <= r_pattern;
          end else begin
            r_req1  <= 1'b1;
            r_addr1 <= r_src + 32'd4;
            r_state <= S_RD;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign err_o    = r_err;
  assign words_o  = r_words;
  assign req1_o   = r_req1;
  assign we1_o    = 1'b0;
  assign be1_o    = 4'b1111;
  assign addr1_o  = r_addr1;
  assign wdata1_o = 32'd0;
  assign req2_o   = r_req2;
  assign we2_o    = r_req2;
  assign be2_o    = 4'b1111;
  assign addr2_o  = r_addr2;
  assign wdata2_o = r_wdata2;

endmodule

// File: tb/tb_ram_copy_dma.sv
// tb/tb_ram_copy_dma.sv - directed self-checking bench for ram_copy_dma
// Contains a 1-cycle-latency RAM model behind both ports.
module tb_ram_copy_dma;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] len_i = '0;
  logic [31:0] pattern_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o;
  logic [1:0]  err_o;
  logic [15:0] words_o;
  logic        req1_o, we1_o, req2_o, we2_o;
  logic [3:0]  be1_o, be2_o;
  logic [31:0] addr1_o, wdata1_o, addr2_o, wdata2_o;
  logic        rvalid1_i = 1'b0;
  logic [31:0] rdata1_i = '0;
  logic        rvalid2_i = 1'b0;
  logic [31:0] rdata2_i = '0;

  logic [31:0] mem [0:2047];
  logic        withhold = 1'b0;
  int          checks = 0;
  int          errs = 0;
  int          cyc, nr1, nr2;

  ram_copy_dma dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .pattern_i(pattern_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .words_o(words_o), .req1_o(req1_o), .we1_o(we1_o),
    .be1_o(be1_o), .addr1_o(addr1_o), .wdata1_o(wdata1_o), .rvalid1_i(rvalid1_i),
    .rdata1_i(rdata1_i), .req2_o(req2_o), .we2_o(we2_o), .be2_o(be2_o),
    .addr2_o(addr2_o), .wdata2_o(wdata2_o), .rvalid2_i(rvalid2_i), .rdata2_i(rdata2_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    rvalid1_i <= req1_o && !withhold;
    rdata1_i  <= mem[addr1_o[12:2]];
    rvalid2_i <= req2_o;
    if (req2_o && we2_o) mem[addr2_o[12:2]] <= wdata2_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic setup(input logic m, input logic [31:0] s, input logic [31:0] d,
                       input logic [15:0] l, input logic [31:0] p);
    mode_i = m; src_addr_i = s; dst_addr_i = d; len_i = l; pattern_i = p;
  endtask

  // Cycle 1 is the first cycle after the start edge; returns the done cycle.
  task automatic run(input int abort_at, input int start_at,
                     output int c, output int r1, output int r2);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    c = 1; r1 = 0; r2 = 0;
    while (!done_o && c < 100) begin
      abort_i = (c == abort_at);
      start_i = (c == start_at);
      if (c == start_at) dst_addr_i = 32'h700;
      tick();
      c++;
      if (req1_o) r1++;
      if (req2_o) r2++;
    end
    abort_i = 1'b0;
    start_i = 1'b0;
    chk("done_seen", {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA5000000 | i;
    mem[0] = 32'h11111111; mem[1] = 32'h22222222;
    mem[2] = 32'h33333333; mem[3] = 32'h44444444;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {30'd0, err_o}, 32'd0);
    chk("rst_words", {16'd0, words_o}, 32'd0);
    chk("rst_req", {30'd0, req1_o, req2_o}, 32'd0);
    chk("rst_be", {24'd0, be1_o, be2_o}, 32'h000000FF);
    chk("rst_addr", addr1_o | addr2_o | wdata2_o, 32'd0);
    tick();

    setup(1'b0, 32'h0, 32'h100, 16'd4, 32'h0);
    run(-1, -1, cyc, nr1, nr2);
    chk("copy_cycles", cyc, 32'd14);
    chk("copy_err", {30'd0, err_o}, 32'd0);
    chk("copy_words", {16'd0, words_o}, 32'd4);
    chk("copy_busy_in_done", {31'd0, busy_o}, 32'd0);
    chk("copy_nreq", {nr1[15:0], nr2[15:0]}, 32'h00040004);
    chk("copy_m0", mem[12'h40], 32'h11111111);
    chk("copy_m1", mem[12'h41], 32'h22222222);
    chk("copy_m2", mem[12'h42], 32'h33333333);
    chk("copy_m3", mem[12'h43], 32'h44444444);
    tick();
    chk("hold_words", {16'd0, words_o}, 32'd4);
    chk("hold_done", {31'd0, done_o}, 32'd0);

    setup(1'b1, 32'h0, 32'h200, 16'd3, 32'hDEADBEEF);
    run(-1, -1, cyc, nr1, nr2);
    chk("fill_cycles", cyc, 32'd5);
    chk("fill_err", {30'd0, err_o}, 32'd0);
    chk("fill_nreq", {nr1[15:0], nr2[15:0]}, 32'h00000003);
    chk("fill_m0", mem[12'h80], 32'hDEADBEEF);
    chk("fill_m2", mem[12'h82], 32'hDEADBEEF);
    chk("fill_m3", mem[12'h83], 32'hA5000083);
    tick();

    setup(1'b0, 32'h0, 32'h300, 16'd0, 32'h0);
    run(-1, -1, cyc, nr1, nr2);
    chk("bad_len0", {cyc[15:0], 14'd0, err_o}, 32'h00020001);
    chk("bad_len0_req", nr1 + nr2, 32'd0);
    tick();
    setup(1'b0, 32'h2, 32'h300, 16'd1, 32'h0);
    run(-1, -1, cyc, nr1, nr2);
    chk("bad_src", {cyc[15:0], 14'd0, err_o}, 32'h00020001);
    chk("bad_src_req", nr1 + nr2, 32'd0);
    tick();
    setup(1'b0, 32'h0, 32'h1FFC, 16'd2, 32'h0);
    run(-1, -1, cyc, nr1, nr2);
    chk("bad_range", {cyc[15:0], 14'd0, err_o}, 32'h00020001);
    chk("bad_range_req", nr1 + nr2, 32'd0);
    chk("bad_mem_untouched", mem[12'h7FF], 32'hA50007FF);
    chk("bad_mem_300", mem[12'hC0], 32'hA50000C0);
    tick();
    setup(1'b1, 32'h0, 32'h1FF8, 16'd2, 32'h5A5A5A5A);
    run(-1, -1, cyc, nr1, nr2);
    chk("edge_range_err", {30'd0, err_o}, 32'd0);
    chk("edge_range_mem", mem[12'h7FF], 32'h5A5A5A5A);
    tick();

    withhold = 1'b1;
    setup(1'b0, 32'h0, 32'h400, 16'd2, 32'h0);
    run(-1, -1, cyc, nr1, nr2);
    withhold = 1'b0;
    chk("tmo_cycles", cyc, 32'd18);
    chk("tmo_err", {30'd0, err_o}, 32'd2);
    chk("tmo_words", {16'd0, words_o}, 32'd0);
    chk("tmo_nreq", {nr1[15:0], nr2[15:0]}, 32'h00010000);
    chk("tmo_mem", mem[12'h100], 32'hA5000100);
    tick(); tick();

    setup(1'b0, 32'h0, 32'h500, 16'd8, 32'h0);
    run(8, -1, cyc, nr1, nr2);
    chk("abort_cycles", cyc, 32'd11);
    chk("abort_err", {30'd0, err_o}, 32'd3);
    chk("abort_words", {16'd0, words_o}, 32'd3);
    chk("abort_m2", mem[12'h142], 32'h33333333);
    chk("abort_m3", mem[12'h143], 32'hA5000143);
    tick();

    setup(1'b0, 32'h0, 32'h600, 16'd4, 32'h0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 7; i++) tick();
    chk("mid_req2_word2", {31'd0, req2_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_outs", {28'd0, req1_o, req2_o, done_o, we2_o}, 32'd0);
    chk("mid_rst_addr2", addr2_o, 32'd0);
    chk("mid_rst_words", {16'd0, words_o}, 32'd0);
    chk("mid_partial", mem[12'h181], 32'h22222222);
    chk("mid_untouched", mem[12'h182], 32'hA5000182);
    tick();

    setup(1'b0, 32'h8, 32'h608, 16'd2, 32'h0);
    run(-1, 3, cyc, nr1, nr2);
    chk("restart_cycles", cyc, 32'd8);
    chk("restart_err", {30'd0, err_o}, 32'd0);
    chk("restart_words", {16'd0, words_o}, 32'd2);
    chk("restart_m0", mem[12'h182], 32'h33333333);
    chk("restart_m1", mem[12'h183], 32'h44444444);
    chk("restart_ignored", mem[12'h1C0], 32'hA50001C0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ram_copy_dma.md
Name: ram_copy_dma

Overview:
- Word-granular block-copy/fill engine that sits directly upstream of dualportram.
- Drives port 1 as a read master (source) and port 2 as a write master (destination).
- A control client issues one descriptor (src, dst, length, mode) per start; the engine moves the data word by word and reports done or error.
- Fill mode writes a constant pattern and does not use port 1.

Parameters:
- RAM_SIZE, 8192, RAM size in bytes; used for range checking.
- LEN_W, 16, width of the word-count field.
- TIMEOUT, 15, maximum cycles to wait for rvalid1_i after a read request before flagging an error.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  descriptor strobe; accepted only in IDLE
- mode_i  in  1  0 = copy, 1 = fill
- src_addr_i  in  32  source byte address (copy mode)
- dst_addr_i  in  32  destination byte address
- len_i  in  LEN_W  number of 32-bit words
- pattern_i  in  32  fill value (fill mode)
- abort_i  in  1  stop after the current word completes
- busy_o  out  1  high from the cycle after acceptance until done
- done_o  out  1  one-cycle completion pulse
- err_o  out  2  status, valid with done_o: 0 ok, 1 bad descriptor, 2 read timeout, 3 aborted
- words_o  out  LEN_W  words written in the current or last transfer
- req1_o  out  1  port-1 request
- we1_o  out  1  port-1 write enable; always 0
- be1_o  out  4  port-1 byte enables; always 4'b1111
- addr1_o  out  32  port-1 address
- wdata1_o  out  32  port-1 write data; always 0
- rvalid1_i  in  1  port-1 read-data valid
- rdata1_i  in  32  port-1 read data
- req2_o  out  1  port-2 request
- we2_o  out  1  port-2 write enable
- be2_o  out  4  port-2 byte enables; always 4'b1111
- addr2_o  out  32  port-2 address
- wdata2_o  out  32  port-2 write data
- rvalid2_i  in  1  port-2 write acknowledge; ignored
- rdata2_i  in  32  port-2 read data; ignored

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high on rst_i.
- Reset values: every output is 0 except be1_o/be2_o = 4'b1111. State goes to IDLE and all internal counters clear.
- rst_i asserted mid-transfer drops any request on the next edge. A partially written destination is left as is.
- RAM contract: a request is accepted on the clock edge where req is high. A read returns rvalid1_i = 1 with data in a later cycle (nominally the next one).
- The engine holds req1_o/req2_o high for exactly one cycle per word and never issues two outstanding reads.
- State IDLE: start_i = 1 latches all descriptor inputs and clears words_o, then moves to CHECK. start_i in any other state is ignored.
- State CHECK (1 cycle): the descriptor is bad if any of the following holds:
  - len = 0;
  - src[1:0] != 0 or dst[1:0] != 0;
  - dst + 4*len > RAM_SIZE;
  - copy mode and src + 4*len > RAM_SIZE.
  - Range arithmetic is done at 34 bits so it cannot wrap.
  - Bad descriptor -> DONE with err = 1. Otherwise -> RD (copy) or WR (fill).
- State RD: req1_o = 1, we1_o = 0, addr1_o = current src. Next state WT with the timeout counter cleared.
- State WT:
  - rvalid1_i = 1 captures rdata1_i into the data buffer and moves to WR.
  - Otherwise the timeout counter increments; once it reaches TIMEOUT without rvalid -> DONE with err = 2.
  - rvalid1_i arriving in any other state is ignored.
- State WR: req2_o = we2_o = 1, addr2_o = current dst, wdata2_o = buffer (copy) or pattern (fill).
  - On leaving WR: words_o increments, src += 4, dst += 4, remaining count decrements.
  - Remaining = 0 -> DONE with err = 0.
  - Otherwise, if abort is pending -> DONE with err = 3.
  - Otherwise -> RD (copy) or stay in WR (fill).
- Abort: abort_i sets a sticky pending flag in any non-IDLE state, honoured only at the WR exit. A word in flight is always completed. abort_i in IDLE has no effect. Completion of the last word takes priority over abort (err = 0).
- State DONE (1 cycle): done_o = 1, busy_o = 0, err_o valid. Then IDLE. err_o and words_o hold until the next accepted start.
- busy_o is high in CHECK, RD, WT and WR.
- Latency with a 1-cycle RAM: copy of N words = 2 + 3N cycles from the start edge to the done_o cycle; fill = 2 + N.
- Address outputs hold their last value while req is low.

Test Plan:
- Preload RAM[0x00..0x0C] = 0x11111111, 0x22222222, 0x33333333, 0x44444444; copy src = 0, dst = 0x100, len = 4 -> RAM[0x100..0x10C] matches, err = 0, words = 4, done_o 14 cycles after start.
- Fill dst = 0x200, len = 3, pattern = 0xDEADBEEF -> RAM[0x200..0x208] = 0xDEADBEEF, req1_o never asserts, done 5 cycles after start, err = 0.
- Bad descriptors (len = 0; src = 0x2; dst = 0x1FFC with len = 2) -> done_o 2 cycles after start, err = 1, no req1_o/req2_o, RAM unchanged.
- Bench withholds rvalid1_i in copy mode -> done_o with err = 2 after TIMEOUT wait cycles, words = 0, no port-2 write.
- Copy with len = 8, abort_i pulsed during word 3's RD -> word 3 written, err = 3, words = 3, RAM[dst+12..] untouched.
- Assert rst_i during WR of word 2 -> all outputs reset next cycle, busy = 0. A new start then completes normally; start_i while busy is ignored.
